// File: rtl/control_segmentacion_pkg.sv
// Shared definitions for the pipeline hazard controller:
//   - estado_t    : controller state encoding (visible on Estado)
//   - FWD_*       : ALU operand source select codes
//   - BUF_*       : bit positions of the pipeline buffers in EnBuf/FlushBuf
//   - buf_mask()  : one-hot mask for a buffer index
package control_segmentacion_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LOAD_USE = 2'b01,
        FLUSH    = 2'b10,
        MEM_WAIT = 2'b11
    } estado_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int NUM_BUF   = 4;
    localparam int BUF_IFID  = 0;
    localparam int BUF_IDEX  = 1;
    localparam int BUF_EXMEM = 2;
    localparam int BUF_MEMWB = 3;

    function automatic logic [NUM_BUF-1:0] buf_mask(input int idx);
        logic [NUM_BUF-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/control_segmentacion_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side, drives the pipeline register fields, reads controls
//   slave  : controller side, reads pipeline fields, drives EnPC/EnBuf/FlushBuf,
//            ForwardA/B, Estado and CntBurbujas
interface control_segmentacion_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] IdRs, IdRt, ExRs, ExRt, ExRd, MemRd, WbRd;
    logic             IdUsaRt, ExMemRead, SaltoTomado;
    logic             MemRegWrite, MemAcceso, MemListo, WbRegWrite;

    logic             EnPC;
    logic [3:0]       EnBuf, FlushBuf;
    logic [1:0]       ForwardA, ForwardB, Estado;
    logic [CNT_W-1:0] CntBurbujas;

    modport master (
        output IdRs, IdRt, IdUsaRt, ExRs, ExRt, ExRd, ExMemRead, SaltoTomado,
               MemRd, MemRegWrite, MemAcceso, MemListo, WbRd, WbRegWrite,
        input  EnPC, EnBuf, FlushBuf, ForwardA, ForwardB, Estado, CntBurbujas
    );

    modport slave (
        input  IdRs, IdRt, IdUsaRt, ExRs, ExRt, ExRd, ExMemRead, SaltoTomado,
               MemRd, MemRegWrite, MemAcceso, MemListo, WbRd, WbRegWrite,
        output EnPC, EnBuf, FlushBuf, ForwardA, ForwardB, Estado, CntBurbujas
    );
endinterface

// File: rtl/control_segmentacion_adelanto.sv
// unidad_adelanto: forwarding select for both ALU operands.
//   ExRs/ExRt          : sources of the instruction in EX
//   MemRd/MemRegWrite  : destination in EX/MEM (newest, wins)
//   WbRd/WbRegWrite    : destination in MEM/WB
//   ForwardA/ForwardB  : FWD_* select for operand A (rs) and B (rt)
module unidad_adelanto
    import control_segmentacion_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ExRs,
    input  logic [REG_W-1:0] ExRt,
    input  logic [REG_W-1:0] MemRd,
    input  logic             MemRegWrite,
    input  logic [REG_W-1:0] WbRd,
    input  logic             WbRegWrite,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB
);

    // Register 0 is hardwired, so a write to it must never be forwarded.
    function automatic logic [1:0] sel(input logic [REG_W-1:0] src);
        if (MemRegWrite && MemRd != '0 && MemRd == src)
            return FWD_EXMEM;
        else if (WbRegWrite && WbRd != '0 && WbRd == src)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign ForwardA = sel(ExRs);
    assign ForwardB = sel(ExRt);

endmodule

// File: rtl/control_segmentacion.sv
// control_segmentacion: hazard controller for a 5-stage pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of control_segmentacion_if
// Stall/flush controls are combinational from the current state and inputs;
// only Estado and the lost-cycle counter CntBurbujas are registered.
module control_segmentacion
    import control_segmentacion_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    control_segmentacion_if.slave bus
);

    estado_t            estado, estado_sig;
    logic [CNT_W-1:0]   cnt;
    logic               espera_mem, carga_uso, burbuja, en_pc;
    logic [NUM_BUF-1:0] en_buf, flush_buf;

    assign espera_mem = bus.MemAcceso && !bus.MemListo;

    assign carga_uso = bus.ExMemRead && (bus.ExRd != '0) &&
                       ((bus.ExRd == bus.IdRs) ||
                        (bus.IdUsaRt && bus.ExRd == bus.IdRt));

    always_comb begin
        en_pc      = 1'b1;
        en_buf     = '1;
        flush_buf  = '0;
        estado_sig = RUN;
        if (espera_mem) begin
            // Freeze everything; a bubble drains into MEM/WB meanwhile.
            en_pc      = 1'b0;
            en_buf     = '0;
            flush_buf  = buf_mask(BUF_MEMWB);
            estado_sig = MEM_WAIT;
        end else if (bus.SaltoTomado) begin
            flush_buf  = buf_mask(BUF_IFID) | buf_mask(BUF_IDEX);
            // FLUSH is entered only from RUN/LOAD_USE; the cycle that leaves
            // MEM_WAIT or FLUSH always returns to RUN.
            estado_sig = (estado == RUN || estado == LOAD_USE) ? FLUSH : RUN;
        end else if (carga_uso && estado != FLUSH) begin
            // Hold PC and IF/ID, bubble into ID/EX.
            en_pc      = 1'b0;
            en_buf     = ~buf_mask(BUF_IFID);
            flush_buf  = buf_mask(BUF_IDEX);
            estado_sig = (estado == MEM_WAIT) ? RUN : LOAD_USE;
        end
    end

    assign burbuja = !en_pc || (|flush_buf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= RUN;
            cnt    <= '0;
        end else begin
            estado <= estado_sig;
            if (burbuja && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.EnPC        = en_pc;
    assign bus.EnBuf       = en_buf;
    assign bus.FlushBuf    = flush_buf;
    assign bus.Estado      = estado;
    assign bus.CntBurbujas = cnt;

    unidad_adelanto #(.REG_W(REG_W)) u_adelanto (
        .ExRs        (bus.ExRs),
        .ExRt        (bus.ExRt),
        .MemRd       (bus.MemRd),
        .MemRegWrite (bus.MemRegWrite),
        .WbRd        (bus.WbRd),
        .WbRegWrite  (bus.WbRegWrite),
        .ForwardA    (bus.ForwardA),
        .ForwardB    (bus.ForwardB)
    );

endmodule
